// File: rtl/arb_merge.sv
// rtl/arb_merge.sv - grant-steered two-input merge into a DEPTH-entry output FIFO.
// Optional per-input transfer counters cnt0/cnt1 are enabled by ARB_MERGE_STATS_EN.
module arb_merge #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel_valid,
  input  logic             sel_data,
  output logic             sel_ready,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef ARB_MERGE_STATS_EN
  ,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, GET0, GET1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             run;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_data;
  logic             in0_fire;
  logic             in1_fire;

  assign full      = (count == (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  assign in0_fire  = in0_valid && in0_ready;
  assign in1_fire  = in1_valid && in1_ready;

  // run holds sel_ready low during reset and until the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_ready = 1'b0;
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    push      = 1'b0;
    push_data = in0_data;
    case (state)
      IDLE: begin
        sel_ready = run;
        if (run && sel_valid) state_nxt = sel_data ? GET1 : GET0;
      end
      GET0: begin
        // a full buffer stalls the grant here rather than dropping it
        in0_ready = !full;
        if (in0_valid && !full) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end
      end
      GET1: begin
        in1_ready = !full;
        push_data = in1_data;
        if (in1_valid && !full) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef ARB_MERGE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (in0_fire && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 1'b1;
      if (in1_fire && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_arb_merge.sv
// tb/tb_arb_merge.sv - randomized bench for arb_merge against a queue-based model.
module tb_arb_merge;
  localparam int WIDTH = 33;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sel_valid, sel_data, sel_ready;
  logic             in0_valid, in0_ready, in1_valid, in1_ready;
  logic [WIDTH-1:0] in0_data, in1_data, out_data;
  logic             out_valid, out_ready;
`ifdef ARB_MERGE_STATS_EN
  logic [15:0]      cnt0, cnt1;
  int               n0, n1;
`endif

  arb_merge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .sel_valid(sel_valid), .sel_data(sel_data), .sel_ready(sel_ready),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
`ifdef ARB_MERGE_STATS_EN
    , .cnt0(cnt0), .cnt1(cnt1)
`endif
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // model: accepted-but-unserved grant, packets in output order, post-reset liveness
  int               pend;
  logic [WIDTH-1:0] q [$];
  bit               alive;
  logic             alt_bit;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit chance(input int pct);
    return $urandom_range(99, 0) < pct;
  endfunction

  task automatic model_clear();
    q.delete();
    pend  = -1;
    alive = 1'b0;
`ifdef ARB_MERGE_STATS_EN
    n0 = 0;
    n1 = 0;
`endif
  endtask

  task automatic idle_inputs();
    sel_valid = 1'b0; sel_data = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0;
    in0_data  = '0;   in1_data  = '0;
    out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel_ready"}, 64'(sel_ready), 64'd0);
    check({tag, "_in0_ready"}, 64'(in0_ready), 64'd0);
    check({tag, "_in1_ready"}, 64'(in1_ready), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
  endtask

  // called at a negedge; pulses reset asynchronously and releases on a later negedge
  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst_async");
    idle_inputs();
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst_held");
    rst_n = 1'b1;
  endtask

  task automatic cycle(input int ps, input int pv0, input int pv1, input int por,
                       input bit s0, input bit alt);
    bit e_sel, e_r0, e_r1, e_ov;
    sel_valid = chance(ps);
    if (s0)       sel_data = 1'b0;
    else if (alt) sel_data = ~alt_bit;
    else          sel_data = 1'($urandom_range(1, 0));
    in0_valid = chance(pv0);
    in1_valid = chance(pv1);
    in0_data  = WIDTH'({$urandom(), $urandom()});
    in1_data  = WIDTH'({$urandom(), $urandom()});
    out_ready = chance(por);

    e_sel = alive && (pend < 0);
    e_r0  = (pend == 0) && (q.size() < DEPTH);
    e_r1  = (pend == 1) && (q.size() < DEPTH);
    e_ov  = (q.size() != 0);
    check("sel_ready", 64'(sel_ready), 64'(e_sel));
    check("in0_ready", 64'(in0_ready), 64'(e_r0));
    check("in1_ready", 64'(in1_ready), 64'(e_r1));
    check("out_valid", 64'(out_valid), 64'(e_ov));
    if (e_ov) check("out_data", 64'(out_data), 64'(q[0]));
`ifdef ARB_MERGE_STATS_EN
    check("cnt0", 64'(cnt0), 64'(n0));
    check("cnt1", 64'(cnt1), 64'(n1));
`endif

    if (e_ov && out_ready) void'(q.pop_front());
    if (in0_valid && e_r0) begin
      q.push_back(in0_data);
      pend = -1;
`ifdef ARB_MERGE_STATS_EN
      if (n0 != 65535) n0++;
`endif
    end
    if (in1_valid && e_r1) begin
      q.push_back(in1_data);
      pend = -1;
`ifdef ARB_MERGE_STATS_EN
      if (n1 != 65535) n1++;
`endif
    end
    if (sel_valid && e_sel) begin
      pend    = int'(sel_data);
      alt_bit = sel_data;
    end
    alive = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    alt_bit = 1'b1;
    idle_inputs();
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst_init");
    rst_n = 1'b1;

    // mixed traffic
    repeat (400) cycle(60, 70, 70, 80, 1'b0, 1'b0);
    do_reset();
    // output back-pressure drives the FIFO to full
    repeat (400) cycle(80, 90, 90, 10, 1'b0, 1'b0);
    do_reset();
    // in1 always valid but only 0-grants issued
    repeat (300) cycle(70, 60, 100, 60, 1'b1, 1'b0);
    do_reset();
    // saturating alternating grants with a free output
    repeat (300) cycle(100, 100, 100, 100, 1'b0, 1'b1);
    do_reset();
    repeat (300) cycle(50, 50, 50, 50, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/arb_merge.md
ARB_MERGE -- requirements
Module: arb_merge

Interface
- REQ-001 SHALL have parameter WIDTH, default 33: packet width in bits.
- REQ-002 SHALL have parameter DEPTH, default 2: output buffer entries; power of two, minimum 2.
- REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk, input, 1, rising-edge clock for all state.
- REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
- REQ-005 SHALL have port sel_valid, input, 1: arbiter grant present.
- REQ-006 SHALL have port sel_data, input, 1: grant value; 0 selects in0, 1 selects in1.
- REQ-007 SHALL have port sel_ready, output, 1: grant accepted when high together with sel_valid.
- REQ-008 SHALL have ports in0_valid/in1_valid, input, 1 each: packet present on the input.
- REQ-009 SHALL have ports in0_data/in1_data, input, WIDTH each: packet payload.
- REQ-010 SHALL have ports in0_ready/in1_ready, output, 1 each: packet consumed.
- REQ-011 SHALL have ports out_valid (output, 1), out_data (output, WIDTH) and out_ready (input, 1): merged packet stream.

Function
- REQ-012 SHALL use a valid/ready handshake on every channel; a transfer occurs on a rising clk edge with valid and ready both high.
- REQ-013 SHALL implement FSM states IDLE, GET0 and GET1.
- REQ-014 IDLE: sel_ready=1; on sel transfer go to GET0 if sel_data=0, else GET1.
- REQ-015 GET0: in0_ready = !full; on in0 transfer, write in0_data to the buffer and return to IDLE.
- REQ-016 GET1: in1_ready = !full; on in1 transfer, write in1_data to the buffer and return to IDLE.
- REQ-017 sel_ready SHALL be 0 outside IDLE; in0_ready SHALL be 0 outside GET0; in1_ready SHALL be 0 outside GET1.
- REQ-018 An input asserting valid without a matching grant SHALL never be consumed.
- REQ-019 Peak throughput SHALL be one packet per 2 cycles; there is no grant lookahead.
- REQ-020 The buffer SHALL be a DEPTH-entry FIFO.
- REQ-021 The FIFO SHALL have read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
- REQ-022 The FIFO SHALL have an occupancy counter of log2(DEPTH)+1 bits.
- REQ-023 out_valid = (count != 0); out_data = FIFO head.
- REQ-024 Pop SHALL occur on an out transfer.
- REQ-025 Write-to-out_valid latency SHALL be 1 cycle; there is no bypass path.
- REQ-026 Full (count==DEPTH): the input ready SHALL be held 0 and the FSM SHALL stay in GETx; the grant is retained, never dropped.
- REQ-027 Pop in the same cycle as full SHALL re-enable ready on the next cycle only, since ready is computed from the registered count.
- REQ-028 Empty: out_valid=0, and out_data is don't-care.
- REQ-029 Simultaneous push and pop when not full and not empty SHALL leave count unchanged, with both pointers advancing.
- REQ-030 out_data SHALL be stable while out_valid=1 and out_ready=0.
- REQ-031 Packet order at the output SHALL equal grant acceptance order.

Reset
- REQ-032 rst_n low SHALL asynchronously force state=IDLE, pointers=0 and count=0.
- REQ-033 While rst_n is low, outputs SHALL be sel_ready=0, in0_ready=0, in1_ready=0 and out_valid=0.
- REQ-034 sel_ready SHALL rise on the first clk edge after rst_n deasserts.
- REQ-035 Reset mid-operation SHALL discard the pending grant and all buffered packets; FIFO storage contents need not be cleared.

Configuration
- REQ-036 Macro ARB_MERGE_STATS_EN, when defined, SHALL add output ports cnt0 and cnt1, 16 bits each.
- REQ-037 cnt0/cnt1 SHALL count in0/in1 packet transfers; they saturate at 16'hFFFF, reset to 0, and are registered with 1-cycle latency.
- REQ-038 Without ARB_MERGE_STATS_EN, the ports and counters SHALL be absent, and data-path behaviour SHALL be identical.

Verification
- REQ-039 Grant 0 then grant 1, in0_data=33'h0_AAAA_0001, in1_data=33'h1_5555_0002, out_ready=1 -> outputs 0_AAAA_0001 then 1_5555_0002 in that order, each out_valid 1 cycle after its input transfer.
- REQ-040 in1_valid=1 held for 10 cycles with only 0-grants issued -> in1_ready stays 0, and only in0 packets appear at the output.
- REQ-041 out_ready=0, DEPTH=2, three grants to in0 -> two packets accepted; the FSM stays in GET0 with in0_ready=0; after one pop, in0_ready=1 on the following cycle and the third packet is accepted.
- REQ-042 out_ready held 1 with continuous alternating grants -> exactly 1 packet per 2 cycles; count never exceeds 1; pointers wrap cleanly over 20 packets.
- REQ-043 rst_n pulsed low in GET1 with FIFO count=1 -> same-edge async clear: out_valid=0, sel_ready=0; after release, IDLE with sel_ready=1 and no stale output.
- REQ-044 With ARB_MERGE_STATS_EN, 70000 in0 transfers -> cnt0=16'hFFFF saturated, cnt1=0.
